spell_io_master: RTL and testbench
==================================

# spell_io_master

Bus initiator for the spell memory-mapped I/O space. It accepts single-register requests from the CPU core over a valid/ready interface and drives the select/addr/write/data bus toward the I/O responder. Supported operations are read, write, and atomic bit-set/bit-clear (read-modify-write). It enforces one deselected gap cycle between transactions, so edge-sensitive registers (PINB toggle) see every write.

## Interface
Parameters:
- TIMEOUT, 15: maximum select cycles per bus phase before abort; legal range 2..255.

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- req_op  in  2  00 read, 01 write, 10 set bits, 11 clear bits
- req_addr  in  8  I/O register address
- req_wdata  in  8  write data (write) or bit mask (set/clear)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  8  read value: read → register value, set/clear → pre-modify value, write → 0x00, error → 0xFF
- rsp_err  out  1  valid with rsp_valid; 1 = timeout abort
- bus_select  out  1  transaction strobe to responder
- bus_addr  out  8  register address, held stable for the whole transaction
- bus_wdata  out  8  write data
- bus_write  out  1  1 = write phase
- bus_rdata  in  8  responder read data
- bus_ready  in  1  responder data_ready

## Operation
- States: IDLE, RD, WR, GAP.
- IDLE: on accept, latch op/addr/wdata. Read/set/clear go to RD; write goes to WR. Clear phase counter and first-cycle flag.
- RD: bus_select=1, bus_write=0. bus_ready is ignored in the first cycle of the phase, because it may be stale from a previous select. Ready sampled in a later cycle captures bus_rdata. Then:
  - read → GAP
  - set → WR with bus_wdata = rdata | mask
  - clear → WR with bus_wdata = rdata & ~mask
- WR: bus_select=1, bus_write=1. bus_ready is ignored in the first cycle. Ready in a later cycle → GAP. Select stays high across an RD→WR transition.
- GAP: bus_select=0, bus_write=0, rsp_valid=1 for exactly this cycle, rsp_rdata/rsp_err valid. Next state is IDLE.
- bus_addr and bus_wdata hold their values outside select cycles. Only bus_select qualifies them.
- rsp_rdata and rsp_err hold their values until the next GAP.
- Reset (including mid-transaction): state IDLE; bus_select, bus_write, rsp_valid, rsp_err = 0; bus_addr, bus_wdata, rsp_rdata = 0x00. No response is issued for an aborted transaction.

## Timing
- Cycle 0 is the cycle in which accept is sampled.
- Read/write:
  - cycle 1: select, first cycle
  - cycle 2: ready captured
  - cycle 3: GAP, rsp_valid
  - cycle 4: IDLE, req_ready=1
  - Throughput is one transaction per 4 cycles against a zero-wait responder.
- Set/clear:
  - cycles 1–2: RD
  - cycles 3–4: WR
  - cycle 5: GAP, rsp_valid
  - cycle 6: IDLE
- req_ready is a decode of state only. It has no combinational path from req_valid.
- A slow responder extends RD/WR one cycle per cycle with no ready.

## Configuration
- SPELL_IOM_TIMEOUT_EN defined:
  - An 8-bit phase counter counts select cycles, including the first.
  - If the TIMEOUT-th cycle passes without a valid ready, the FSM goes to GAP with rsp_err=1 and rsp_rdata=0xFF. The RMW write phase is skipped.
  - Ready sampled in the TIMEOUT-th cycle is still accepted.
- Not defined: no counter; phases wait indefinitely; rsp_err tied 0.

## Test plan
- Write 0x38 ← 0xA5, then read 0x38: bus_select high in cycles 1–2, rsp_valid in cycle 3, req_ready in cycle 4; the read returns rsp_rdata=0xA5, rsp_err=0.
- DDRB=0x0F, set op with mask 0xF0 at 0x37: rsp_rdata=0x0F, DDRB=0xFF, rsp_valid in cycle 5; then clear op with mask 0x3C: rsp_rdata=0xFF, DDRB=0xC3.
- Back-to-back writes to 0x36 with 0x01, req_valid held high, PORTB initially 0x00: bus_select low for one cycle between them; PORTB goes 0x01 then 0x00.
- Stale-ready check: responder keeps bus_ready high in the first select cycle with bus_rdata=0x55, then presents 0x66 with ready in the next cycle: rsp_rdata=0x66.
- With SPELL_IOM_TIMEOUT_EN defined and TIMEOUT=4, responder never ready: bus_select high in cycles 1–4; cycle 5 has rsp_valid=1, rsp_err=1, rsp_rdata=0xFF. Set op on the same stub: no write phase is issued.
- rst_n low during WR of a set op: bus_select=0 and state IDLE on the next cycle, no rsp_valid; a following read of 0x3B completes normally.

Source files
------------

// File: rtl/spell_io_master.sv
// Bus initiator for the spell MMIO space: read, write and atomic set/clear with a deselected gap cycle.
// Optional per-phase select timeout is compiled in when SPELL_IOM_TIMEOUT_EN is defined.
module spell_io_master #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       bus_select,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_write,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ready
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : gBadTimeout
        $error("spell_io_master: TIMEOUT must lie in 2..255");
    end

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_op;
    logic [7:0] r_mask;
    logic [7:0] r_rdata;
    logic       r_first;
    logic [7:0] r_addr;
    logic [7:0] r_bus_wdata;
    logic [7:0] r_rsp_rdata;
    logic       w_accept;
    logic       w_in_phase;
    logic       w_done;
    logic       w_timeout;
    logic       w_enter_gap;

    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_in_phase  = (r_state == RD) || (r_state == WR);
    // Ready seen in the first select cycle may be left over from the previous select
    assign w_done      = w_in_phase && !r_first && bus_ready;
    assign w_enter_gap = (w_next_state == GAP) && (r_state != GAP);

`ifdef SPELL_IOM_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_now;
    logic       r_rsp_err;

    // w_cnt_now is the 1-based index of the current select cycle within its phase
    assign w_cnt_now = r_cnt + 8'd1;
    assign w_timeout = w_in_phase && !w_done && (w_cnt_now == 8'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_next_state != r_state) begin
            r_cnt <= 8'd0;
        end else if (w_in_phase) begin
            r_cnt <= w_cnt_now;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_enter_gap) begin
            r_rsp_err <= w_timeout;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus strobes and handshakes are pure state decodes, so req_ready never depends on req_valid
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        bus_select   = 1'b0;
        bus_write    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = (req_op == OP_WR) ? WR : RD;
                end
            end
            RD: begin
                bus_select = 1'b1;
                if (w_done) begin
                    w_next_state = (r_op == OP_RD) ? GAP : WR;
                end else if (w_timeout) begin
                    w_next_state = GAP;
                end
            end
            WR: begin
                bus_select = 1'b1;
                bus_write  = 1'b1;
                if (w_done || w_timeout) begin
                    w_next_state = GAP;
                end
            end
            GAP: begin
                rsp_valid    = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch, read capture, read-modify-write data and response value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op        <= OP_RD;
            r_mask      <= 8'h00;
            r_rdata     <= 8'h00;
            r_first     <= 1'b0;
            r_addr      <= 8'h00;
            r_bus_wdata <= 8'h00;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_first <= (w_next_state != r_state);
            if (w_accept) begin
                r_op   <= req_op;
                r_addr <= req_addr;
                r_mask <= req_wdata;
                if (req_op == OP_WR) begin
                    r_bus_wdata <= req_wdata;
                end
            end
            if ((r_state == RD) && w_done) begin
                r_rdata <= bus_rdata;
                case (r_op)
                    OP_SET:  r_bus_wdata <= bus_rdata | r_mask;
                    OP_CLR:  r_bus_wdata <= bus_rdata & ~r_mask;
                    default: ;
                endcase
            end
            if (w_enter_gap) begin
                if (w_timeout) begin
                    r_rsp_rdata <= 8'hFF;
                end else begin
                    case (r_op)
                        OP_RD:   r_rsp_rdata <= bus_rdata;
                        OP_WR:   r_rsp_rdata <= 8'h00;
                        default: r_rsp_rdata <= r_rdata;
                    endcase
                end
            end
        end
    end

    assign bus_addr  = r_addr;
    assign bus_wdata = r_bus_wdata;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_spell_io_master.sv
// Directed bench for spell_io_master with a small register-file responder (PINB toggles PORTB).
// Build with SPELL_IOM_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT=4).
module tb_spell_io_master;

`ifdef SPELL_IOM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 15;
`endif

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       bus_select;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_write;
   logic [7:0] bus_rdata;
   logic       bus_ready;

   logic [7:0] regs [256];
   logic       wasWrite;
   int         selCount;
   int         respMode;
   logic       respInit;

   int vectorCount = 0;
   int missCount   = 0;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      int          mode;
      logic [7:0]  expRdata;
      logic        expErr;
      int          expLat;
      logic [15:0] expSel;
      logic [15:0] expWr;
   } vec_t;

   vec_t vecs[$];

   spell_io_master #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .bus_select (bus_select),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_write  (bus_write),
      .bus_rdata  (bus_rdata),
      .bus_ready  (bus_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder register file: writes commit on the rising edge of a write strobe, 0x36 toggles 0x38
   always @(posedge clk) begin
      if (respInit) begin
         for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
         regs[8'h3B] <= 8'h5A;
         wasWrite    <= 1'b0;
         selCount    <= 0;
      end else begin
         wasWrite <= bus_select && bus_write;
         selCount <= bus_select ? selCount + 1 : 0;
         if (bus_select && bus_write && !wasWrite) begin
            if (bus_addr == 8'h36) regs[8'h38] <= regs[8'h38] ^ bus_wdata;
            else                   regs[bus_addr] <= bus_wdata;
         end
      end
   end

   // Mode 0 zero-wait, 1 never ready, 2 stale ready (0x55 then 0x66), 3 ready from 6th select cycle
   always_comb begin
      bus_ready = 1'b0;
      bus_rdata = regs[bus_addr];
      case (respMode)
         0: bus_ready = bus_select;
         2: begin
            bus_ready = 1'b1;
            bus_rdata = (selCount == 0) ? 8'h55 : 8'h66;
         end
         3: bus_ready = bus_select && (selCount >= 5);
         default: bus_ready = 1'b0;
      endcase
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One request from IDLE; records select/write per cycle (bit c = cycle c) and the rsp_valid cycle
   task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                                output logic [7:0] rdata, output logic err, output int lat,
                                output logic [15:0] selMask, output logic [15:0] wrMask,
                                output logic readyAfter, output logic [7:0] rdataAfter);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat     = -1;
      selMask = '0;
      wrMask  = '0;
      rdata   = 8'h00;
      err     = 1'b0;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         @(negedge clk);
         if (c < 16) begin
            selMask[c] = bus_select;
            wrMask[c]  = bus_write;
         end
         if (rsp_valid) begin
            lat   = c;
            rdata = rsp_rdata;
            err   = rsp_err;
         end
      end
      @(negedge clk);
      readyAfter = req_ready;
      rdataAfter = rsp_rdata;
   endtask

   initial begin
      logic [7:0]  rdata;
      logic        err;
      int          lat;
      logic [15:0] selMask;
      logic [15:0] wrMask;
      logic        readyAfter;
      logic [7:0]  rdataAfter;
      logic [8:0]  selPat;
      logic [7:0]  port1;
      logic [7:0]  port2;
      int          rspCount;
      logic        sawRsp;

      vecs.push_back(vec_t'{OP_WR,  8'h38, 8'hA5, 0, 8'h00, 1'b0, 3, 16'h0006, 16'h0006});
      vecs.push_back(vec_t'{OP_RD,  8'h38, 8'h00, 0, 8'hA5, 1'b0, 3, 16'h0006, 16'h0000});
      vecs.push_back(vec_t'{OP_WR,  8'h37, 8'h0F, 0, 8'h00, 1'b0, 3, 16'h0006, 16'h0006});
      vecs.push_back(vec_t'{OP_SET, 8'h37, 8'hF0, 0, 8'h0F, 1'b0, 5, 16'h001E, 16'h0018});
      vecs.push_back(vec_t'{OP_RD,  8'h37, 8'h00, 0, 8'hFF, 1'b0, 3, 16'h0006, 16'h0000});
      vecs.push_back(vec_t'{OP_CLR, 8'h37, 8'h3C, 0, 8'hFF, 1'b0, 5, 16'h001E, 16'h0018});
      vecs.push_back(vec_t'{OP_RD,  8'h37, 8'h00, 0, 8'hC3, 1'b0, 3, 16'h0006, 16'h0000});
      vecs.push_back(vec_t'{OP_RD,  8'h20, 8'h00, 2, 8'h66, 1'b0, 3, 16'h0006, 16'h0000});
`ifdef SPELL_IOM_TIMEOUT_EN
      vecs.push_back(vec_t'{OP_RD,  8'h38, 8'h00, 1, 8'hFF, 1'b1, 5, 16'h001E, 16'h0000});
      vecs.push_back(vec_t'{OP_SET, 8'h37, 8'h01, 1, 8'hFF, 1'b1, 5, 16'h001E, 16'h0000});
      vecs.push_back(vec_t'{OP_RD,  8'h37, 8'h00, 0, 8'hC3, 1'b0, 3, 16'h0006, 16'h0000});
`else
      vecs.push_back(vec_t'{OP_RD,  8'h38, 8'h00, 3, 8'hA5, 1'b0, 7, 16'h007E, 16'h0000});
`endif

      rst_n     = 1'b0;
      respInit  = 1'b1;
      respMode  = 0;
      req_valid = 1'b0;
      req_op    = OP_RD;
      req_addr  = 8'h00;
      req_wdata = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_req_ready",  {31'd0, req_ready},  32'd1);
      checkOutput("reset_bus_select", {31'd0, bus_select}, 32'd0);
      checkOutput("reset_bus_write",  {31'd0, bus_write},  32'd0);
      checkOutput("reset_rsp_valid",  {31'd0, rsp_valid},  32'd0);
      checkOutput("reset_rsp_err",    {31'd0, rsp_err},    32'd0);
      checkOutput("reset_rsp_rdata",  {24'd0, rsp_rdata},  32'h00);
      checkOutput("reset_bus_addr",   {24'd0, bus_addr},   32'h00);
      checkOutput("reset_bus_wdata",  {24'd0, bus_wdata},  32'h00);
      rst_n    = 1'b1;
      respInit = 1'b0;

      // Back-to-back PINB writes with req_valid held: the gap lets both toggles land
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_WR;
      req_addr  = 8'h36;
      req_wdata = 8'h01;
      selPat    = '0;
      rspCount  = 0;
      port1     = 8'h00;
      port2     = 8'h00;
      for (int c = 0; c <= 8; c++) begin
         selPat[c] = bus_select;
         if (rsp_valid) rspCount++;
         if (c == 3) port1 = regs[8'h38];
         if (c == 8) port2 = regs[8'h38];
         if (c == 5) req_valid = 1'b0;
         @(negedge clk);
      end
      checkOutput("b2b_select_pattern", {23'd0, selPat}, 32'h066);
      checkOutput("b2b_portb_first",    {24'd0, port1},  32'h01);
      checkOutput("b2b_portb_second",   {24'd0, port2},  32'h00);
      checkOutput("b2b_rsp_count",      rspCount,        32'd2);

      for (int i = 0; i < vecs.size(); i++) begin
         respMode = vecs[i].mode;
         applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata,
                       rdata, err, lat, selMask, wrMask, readyAfter, rdataAfter);
         checkOutput($sformatf("v%0d_rdata", i),   {24'd0, rdata},     {24'd0, vecs[i].expRdata});
         checkOutput($sformatf("v%0d_err", i),     {31'd0, err},       {31'd0, vecs[i].expErr});
         checkOutput($sformatf("v%0d_latency", i), lat,                vecs[i].expLat);
         checkOutput($sformatf("v%0d_select", i),  {16'd0, selMask},   {16'd0, vecs[i].expSel});
         checkOutput($sformatf("v%0d_write", i),   {16'd0, wrMask},    {16'd0, vecs[i].expWr});
         checkOutput($sformatf("v%0d_ready", i),   {31'd0, readyAfter}, 32'd1);
         checkOutput($sformatf("v%0d_hold", i),    {24'd0, rdataAfter}, {24'd0, vecs[i].expRdata});
      end
      respMode = 0;

      // Reset asserted during the write phase of a set op drops the transaction silently
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_SET;
      req_addr  = 8'h37;
      req_wdata = 8'h01;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstmid_in_write", {31'd0, bus_write}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rstmid_bus_select", {31'd0, bus_select}, 32'd0);
      checkOutput("rstmid_req_ready",  {31'd0, req_ready},  32'd1);
      checkOutput("rstmid_rsp_rdata",  {24'd0, rsp_rdata},  32'h00);
      sawRsp = rsp_valid;
      rst_n  = 1'b1;
      repeat (4) begin
         @(negedge clk);
         sawRsp = sawRsp | rsp_valid;
      end
      checkOutput("rstmid_no_rsp", {31'd0, sawRsp}, 32'd0);

      applyStimulus(OP_RD, 8'h3B, 8'h00, rdata, err, lat, selMask, wrMask, readyAfter, rdataAfter);
      checkOutput("post_rst_rdata",   {24'd0, rdata}, 32'h5A);
      checkOutput("post_rst_err",     {31'd0, err},   32'd0);
      checkOutput("post_rst_latency", lat,            32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
